// File: rtl/fifo_param_v2.sv
// rtl/fifo_param_v2.sv - parametrised synchronous FIFO with exact count, level flags and sticky errors
// Registered or first-word fall-through read path selected by FWFT.
module fifo_param_v2 #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             n_we_i,
    input  logic             n_re_i,
    input  logic             n_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic [15:0]      bytes_in_fifo_o,
    output logic             p_empty_o,
    output logic             p_full_o,
    output logic             p_aempty_o,
    output logic             p_afull_o,
    output logic             p_overflow_o,
    output logic             p_underflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]   DEPTH16  = 16'(DEPTH);
    localparam logic [15:0]   AFULL16  = 16'(AFULL_TH);
    localparam logic [15:0]   AEMPTY16 = 16'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] data_q, fwft_d;
    logic             empty_q, full_q, aempty_q, afull_q, ovf_q, unf_q;
    logic             empty_c, full_c, rd_acc, wr_acc, head_new;

    always_comb begin
        empty_c  = (count_q == 16'd0);
        full_c   = (count_q == DEPTH16);
        rd_acc   = !n_re_i && !empty_c;
        wr_acc   = !n_we_i && (!full_c || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (wr_acc && !rd_acc)
            count_d = count_q + 16'd1;
        else if (rd_acc && !wr_acc)
            count_d = count_q - 16'd1;
        // The word written this edge becomes the head when nothing else remains ahead of it.
        head_new = wr_acc && (count_q == (rd_acc ? 16'd1 : 16'd0));
        if (count_d == 16'd0)
            fwft_d = '0;
        else if (head_new)
            fwft_d = data_i;
        else
            fwft_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst && n_clr_i && wr_acc)
            mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (!n_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == 16'd0);
            full_q   <= (count_d == DEPTH16);
            aempty_q <= (count_d <= AEMPTY16);
            afull_q  <= (count_d >= AFULL16);
            ovf_q    <= ovf_q | (!n_we_i && !wr_acc);
            unf_q    <= unf_q | (!n_re_i && empty_c);
            if (FWFT != 0)
                data_q <= fwft_d;
            else if (rd_acc)
                data_q <= mem[rd_ptr_q];
        end
    end

    assign data_o          = data_q;
    assign bytes_in_fifo_o = count_q;
    assign p_empty_o       = empty_q;
    assign p_full_o        = full_q;
    assign p_aempty_o      = aempty_q;
    assign p_afull_o       = afull_q;
    assign p_overflow_o    = ovf_q;
    assign p_underflow_o   = unf_q;

endmodule

// File: tb/tb_fifo_param_v2.sv
// tb/tb_fifo_param_v2.sv - directed bench for fifo_param_v2 (registered DEPTH=5 and FWFT DEPTH=4 instances)
module tb_fifo_param_v2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  data_a = '0, data_b = '0;
    logic        nwe_a = 1'b1, nre_a = 1'b1, nclr_a = 1'b1;
    logic        nwe_b = 1'b1, nre_b = 1'b1, nclr_b = 1'b1;
    logic [7:0]  q_a, q_b;
    logic [15:0] cnt_a, cnt_b;
    logic        emp_a, ful_a, ae_a, af_a, ovf_a, unf_a;
    logic        emp_b, ful_b, ae_b, af_b, ovf_b, unf_b;

    int passed = 0;
    int total  = 0;

    fifo_param_v2 #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1)) dut_a (
        .clk(clk), .rst(rst), .data_i(data_a), .n_we_i(nwe_a), .n_re_i(nre_a), .n_clr_i(nclr_a),
        .data_o(q_a), .bytes_in_fifo_o(cnt_a), .p_empty_o(emp_a), .p_full_o(ful_a),
        .p_aempty_o(ae_a), .p_afull_o(af_a), .p_overflow_o(ovf_a), .p_underflow_o(unf_a)
    );

    fifo_param_v2 #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(0)) dut_b (
        .clk(clk), .rst(rst), .data_i(data_b), .n_we_i(nwe_b), .n_re_i(nre_b), .n_clr_i(nclr_b),
        .data_o(q_b), .bytes_in_fifo_o(cnt_b), .p_empty_o(emp_b), .p_full_o(ful_b),
        .p_aempty_o(ae_b), .p_afull_o(af_b), .p_overflow_o(ovf_b), .p_underflow_o(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] d);
        data_a = d; nwe_a = 1'b0; step(); nwe_a = 1'b1;
    endtask

    task automatic rd_a();
        nre_a = 1'b0; step(); nre_a = 1'b1;
    endtask

    initial begin
        step(); step();
        chk("rst_count", cnt_a, 0);
        chk("rst_empty", emp_a, 1);
        chk("rst_full", ful_a, 0);
        chk("rst_aempty", ae_a, 1);
        chk("rst_afull", af_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_unf", unf_a, 0);
        chk("rst_data", q_a, 0);
        chk("rst_b_data", q_b, 0);
        rst = 1'b1;

        wr_a(8'h11); chk("w1_count", cnt_a, 1);
        wr_a(8'h22); chk("w2_count", cnt_a, 2);
        wr_a(8'h33);
        chk("w3_count", cnt_a, 3);
        chk("w3_empty", emp_a, 0);
        chk("w3_aempty", ae_a, 0);
        rd_a(); chk("r1_data", q_a, 8'h11); chk("r1_aempty", ae_a, 0);
        rd_a(); chk("r2_data", q_a, 8'h22); chk("r2_aempty", ae_a, 1);
        rd_a(); chk("r3_data", q_a, 8'h33); chk("r3_empty", emp_a, 1);

        for (int i = 1; i <= 5; i++) begin
            wr_a(8'(i));
            chk("fill_afull", af_a, (i >= 4) ? 1 : 0);
            chk("fill_full", ful_a, (i == 5) ? 1 : 0);
        end
        chk("fill_count", cnt_a, 5);
        wr_a(8'hEE);
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_count", cnt_a, 5);

        data_a = 8'hAA; nwe_a = 1'b0; nre_a = 1'b0; step(); nwe_a = 1'b1; nre_a = 1'b1;
        chk("wrfull_data", q_a, 8'h01);
        chk("wrfull_count", cnt_a, 5);
        chk("wrfull_full", ful_a, 1);
        rd_a(); chk("drain0", q_a, 8'h02);
        rd_a(); chk("drain1", q_a, 8'h03);
        rd_a(); chk("drain2", q_a, 8'h04);
        rd_a(); chk("drain3", q_a, 8'h05);
        rd_a(); chk("drain4", q_a, 8'hAA);
        chk("drain_empty", emp_a, 1);
        chk("drain_ovf_sticky", ovf_a, 1);

        rd_a();
        chk("unf_flag", unf_a, 1);
        chk("unf_data_hold", q_a, 8'hAA);
        chk("unf_count", cnt_a, 0);
        data_a = 8'h77; nwe_a = 1'b0; nre_a = 1'b0; step(); nwe_a = 1'b1; nre_a = 1'b1;
        chk("wre_count", cnt_a, 1);
        chk("wre_unf", unf_a, 1);
        chk("wre_data", q_a, 8'hAA);
        rd_a(); chk("wre_read", q_a, 8'h77);

        for (int i = 0; i < 12; i++) begin
            wr_a(8'(8'h40 + i));
            rd_a();
            chk("wrap_data", q_a, 8'h40 + i);
        end
        chk("wrap_empty", emp_a, 1);

        wr_a(8'h01); wr_a(8'h02);
        nclr_a = 1'b0; step(); nclr_a = 1'b1;
        chk("clr_count", cnt_a, 0);
        chk("clr_empty", emp_a, 1);
        chk("clr_ovf", ovf_a, 0);
        chk("clr_unf", unf_a, 0);
        chk("clr_data", q_a, 0);

        wr_a(8'h99);
        chk("arst_pre_count", cnt_a, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", cnt_a, 0);
        chk("arst_empty", emp_a, 1);
        step();
        rst = 1'b1;

        data_b = 8'h5C; nwe_b = 1'b0; step(); nwe_b = 1'b1;
        chk("fw_first", q_b, 8'h5C);
        chk("fw_count", cnt_b, 1);
        step(); chk("fw_hold", q_b, 8'h5C);
        data_b = 8'h6D; nwe_b = 1'b0; step(); nwe_b = 1'b1;
        chk("fw_head_kept", q_b, 8'h5C);
        nre_b = 1'b0; step(); nre_b = 1'b1;
        chk("fw_next", q_b, 8'h6D);
        nre_b = 1'b0; step(); nre_b = 1'b1;
        chk("fw_empty_data", q_b, 0);
        chk("fw_empty", emp_b, 1);
        data_b = 8'h42; nwe_b = 1'b0; nre_b = 1'b0; step(); nwe_b = 1'b1; nre_b = 1'b1;
        chk("fw_wre_data", q_b, 8'h42);
        chk("fw_wre_unf", unf_b, 1);
        data_b = 8'h5C; nwe_b = 1'b0; step();
        nre_b = 1'b0; nclr_b = 1'b0; step();
        nwe_b = 1'b1; nre_b = 1'b1; nclr_b = 1'b1;
        chk("fw_clr_count", cnt_b, 0);
        chk("fw_clr_empty", emp_b, 1);
        chk("fw_clr_unf", unf_b, 0);
        chk("fw_clr_ovf", ovf_b, 0);
        chk("fw_clr_afull", af_b, 0);
        chk("fw_clr_data", q_b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
